// File: rtl/spu_dual_issue_ctrl_pkg.sv
// Shared types, constants and hazard helpers for the SPU dual-issue dispatch controller.
package spu_dual_issue_ctrl_pkg;

  localparam int REG_AW_P   = 7;
  localparam int EVEN_LAT_P = 2;
  localparam int ODD_LAT_P  = 4;

  // bit positions inside the {writes_rt, reads_rb, reads_ra} use vector
  localparam int USE_RA = 0;
  localparam int USE_RB = 1;
  localparam int USE_RT = 2;

  typedef logic [10:0] Opcodes;
  localparam Opcodes OP_ADD_WORD                      = 11'b00011000000;
  localparam Opcodes OP_SHIFT_LEFT_HALFWORD_IMMEDIATE = 11'b00001111111;

  typedef enum logic {PIPE_EVEN = 1'b0, PIPE_ODD = 1'b1} pipe_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HOLD2 = 2'd1,
    ST_HOLD1 = 2'd2
  } state_e;

  typedef struct packed {
    Opcodes                op;
    logic [REG_AW_P-1:0]   rt;
    logic [REG_AW_P-1:0]   ra;
    logic [REG_AW_P-1:0]   rb;
    logic [2:0]            uses;
    pipe_e                 pipe;
  } issue_pkt_t;

  // busy is ordered {rt, rb, ra} so it lines up with the use vector
  function automatic logic hazard_free(issue_pkt_t p, logic [2:0] busy);
    return (p.uses & busy) == 3'b000;
  endfunction

  function automatic logic pair_dep(issue_pkt_t a, issue_pkt_t b);
    return a.uses[USE_RT] &
           ((b.uses[USE_RA] & (b.ra == a.rt)) |
            (b.uses[USE_RB] & (b.rb == a.rt)) |
            (b.uses[USE_RT] & (b.rt == a.rt)));
  endfunction

endpackage

// File: rtl/spu_dual_issue_ctrl_scoreboard.sv
// Per-register result-latency scoreboard: two load ports, global decrement, six busy reads.
module spu_scoreboard
  import spu_dual_issue_ctrl_pkg::*;
#(
  parameter int NUM_REGS = 128,
  parameter int REG_AW   = REG_AW_P
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld0_en,
  input  logic [REG_AW-1:0] ld0_rt,
  input  logic [2:0]        ld0_lat,
  input  logic              ld1_en,
  input  logic [REG_AW-1:0] ld1_rt,
  input  logic [2:0]        ld1_lat,
  input  logic [REG_AW-1:0] rd_addr [6],
  output logic [5:0]        busy
);

  logic [2:0] cnt_r [NUM_REGS];

  // Counter update: a load beats the saturating decrement on the same register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        cnt_r[i] <= 3'd0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (ld0_en && (ld0_rt == REG_AW'(i))) begin
          cnt_r[i] <= ld0_lat;
        end else if (ld1_en && (ld1_rt == REG_AW'(i))) begin
          cnt_r[i] <= ld1_lat;
        end else if (cnt_r[i] != 3'd0) begin
          cnt_r[i] <= cnt_r[i] - 3'd1;
        end else begin
          cnt_r[i] <= 3'd0;
        end
      end
    end
  end

  // Busy lookup for the held instructions' operands.
  always_comb begin
    busy = 6'd0;
    for (int k = 0; k < 6; k++) begin
      busy[k] = (cnt_r[rd_addr[k]] != 3'd0);
    end
  end

endmodule

// File: rtl/spu_dual_issue_ctrl.sv
// Dual-issue dispatch controller: two-slot pair buffer, hazard check and even/odd pipe routing.
module spu_dual_issue_ctrl
  import spu_dual_issue_ctrl_pkg::*;
#(
  parameter int NUM_REGS = 128,
  parameter int REG_AW   = REG_AW_P,
  parameter int EVEN_LAT = EVEN_LAT_P,
  parameter int ODD_LAT  = ODD_LAT_P
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_v1,
  input  logic [10:0]       in_op0,
  input  logic [10:0]       in_op1,
  input  logic              in_pipe0,
  input  logic              in_pipe1,
  input  logic [REG_AW-1:0] in_rt0,
  input  logic [REG_AW-1:0] in_ra0,
  input  logic [REG_AW-1:0] in_rb0,
  input  logic [REG_AW-1:0] in_rt1,
  input  logic [REG_AW-1:0] in_ra1,
  input  logic [REG_AW-1:0] in_rb1,
  input  logic [2:0]        in_use0,
  input  logic [2:0]        in_use1,
  input  logic              flush,
  output logic              ev_valid,
  output logic              od_valid,
  output logic [10:0]       ev_op,
  output logic [10:0]       od_op,
  output logic [REG_AW-1:0] ev_rt,
  output logic [REG_AW-1:0] ev_ra,
  output logic [REG_AW-1:0] ev_rb,
  output logic [REG_AW-1:0] od_rt,
  output logic [REG_AW-1:0] od_ra,
  output logic [REG_AW-1:0] od_rb
);

  localparam logic [2:0] EV_LAT3 = 3'(EVEN_LAT);
  localparam logic [2:0] OD_LAT3 = 3'(ODD_LAT);

  state_e            state_r, state_nxt_s;
  issue_pkt_t        slot_a_r, slot_b_r, slot_a_nxt_s, slot_b_nxt_s, pkt0_s, pkt1_s;
  logic [5:0]        busy_s;
  logic [REG_AW-1:0] rd_addr_s [6];
  logic              a_iss_s, b_iss_s, accept_s, in_ready_s;
  logic              ev_from_a_s, od_from_a_s, ev_sel_s, od_sel_s;

  assign pkt0_s = '{op: in_op0, rt: in_rt0, ra: in_ra0, rb: in_rb0,
                    uses: in_use0, pipe: pipe_e'(in_pipe0)};
  assign pkt1_s = '{op: in_op1, rt: in_rt1, ra: in_ra1, rb: in_rb1,
                    uses: in_use1, pipe: pipe_e'(in_pipe1)};

  // Operand addresses for the scoreboard: A in ports 0..2, B in ports 3..5.
  always_comb begin
    rd_addr_s[0] = slot_a_r.ra;
    rd_addr_s[1] = slot_a_r.rb;
    rd_addr_s[2] = slot_a_r.rt;
    rd_addr_s[3] = slot_b_r.ra;
    rd_addr_s[4] = slot_b_r.rb;
    rd_addr_s[5] = slot_b_r.rt;
  end

  spu_scoreboard #(.NUM_REGS(NUM_REGS), .REG_AW(REG_AW)) u_sb (
    .clk     (clk),
    .rst     (rst),
    .ld0_en  (a_iss_s && slot_a_r.uses[USE_RT]),
    .ld0_rt  (slot_a_r.rt),
    .ld0_lat ((slot_a_r.pipe == PIPE_ODD) ? OD_LAT3 : EV_LAT3),
    .ld1_en  (b_iss_s && slot_b_r.uses[USE_RT]),
    .ld1_rt  (slot_b_r.rt),
    .ld1_lat ((slot_b_r.pipe == PIPE_ODD) ? OD_LAT3 : EV_LAT3),
    .rd_addr (rd_addr_s),
    .busy    (busy_s)
  );

  // B only ever rides along with A, on the other pipe, with no dependence on A.
  assign a_iss_s = (state_r != ST_EMPTY) && hazard_free(slot_a_r, busy_s[2:0]);
  assign b_iss_s = (state_r == ST_HOLD2) && a_iss_s &&
                   (slot_b_r.pipe != slot_a_r.pipe) &&
                   hazard_free(slot_b_r, busy_s[5:3]) &&
                   !pair_dep(slot_a_r, slot_b_r);

  assign in_ready_s = !rst && !flush &&
                      ((state_r == ST_EMPTY) || ((state_r == ST_HOLD1) && a_iss_s) || b_iss_s);
  assign in_ready   = in_ready_s;
  assign accept_s   = in_valid && in_ready_s;

  assign ev_from_a_s = a_iss_s && (slot_a_r.pipe == PIPE_EVEN);
  assign od_from_a_s = a_iss_s && (slot_a_r.pipe == PIPE_ODD);
  assign ev_sel_s    = ev_from_a_s || (b_iss_s && (slot_b_r.pipe == PIPE_EVEN));
  assign od_sel_s    = od_from_a_s || (b_iss_s && (slot_b_r.pipe == PIPE_ODD));

  // Next buffer state; an accepted pair always replaces whatever just issued.
  always_comb begin
    state_nxt_s  = state_r;
    slot_a_nxt_s = slot_a_r;
    slot_b_nxt_s = slot_b_r;
    if (flush) begin
      state_nxt_s  = ST_EMPTY;
      slot_a_nxt_s = {$bits(issue_pkt_t){1'b0}};
      slot_b_nxt_s = {$bits(issue_pkt_t){1'b0}};
    end else if (accept_s) begin
      slot_a_nxt_s = pkt0_s;
      slot_b_nxt_s = pkt1_s;
      state_nxt_s  = in_v1 ? ST_HOLD2 : ST_HOLD1;
    end else begin
      case (state_r)
        ST_HOLD2: begin
          if (b_iss_s) begin
            state_nxt_s = ST_EMPTY;
          end else if (a_iss_s) begin
            slot_a_nxt_s = slot_b_r;
            state_nxt_s  = ST_HOLD1;
          end else begin
            state_nxt_s = ST_HOLD2;
          end
        end
        ST_HOLD1: begin
          if (a_iss_s) begin
            state_nxt_s = ST_EMPTY;
          end else begin
            state_nxt_s = ST_HOLD1;
          end
        end
        default: state_nxt_s = ST_EMPTY;
      endcase
    end
  end

  // State and slot registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_EMPTY;
      slot_a_r <= {$bits(issue_pkt_t){1'b0}};
      slot_b_r <= {$bits(issue_pkt_t){1'b0}};
    end else begin
      state_r  <= state_nxt_s;
      slot_a_r <= slot_a_nxt_s;
      slot_b_r <= slot_b_nxt_s;
    end
  end

  // Registered issue ports; fields hold their last value while the strobe is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      ev_valid <= 1'b0;
      od_valid <= 1'b0;
      ev_op    <= 11'd0;
      od_op    <= 11'd0;
      ev_rt    <= {REG_AW{1'b0}};
      ev_ra    <= {REG_AW{1'b0}};
      ev_rb    <= {REG_AW{1'b0}};
      od_rt    <= {REG_AW{1'b0}};
      od_ra    <= {REG_AW{1'b0}};
      od_rb    <= {REG_AW{1'b0}};
    end else begin
      ev_valid <= ev_sel_s;
      od_valid <= od_sel_s;
      if (ev_sel_s) begin
        ev_op <= ev_from_a_s ? slot_a_r.op : slot_b_r.op;
        ev_rt <= ev_from_a_s ? slot_a_r.rt : slot_b_r.rt;
        ev_ra <= ev_from_a_s ? slot_a_r.ra : slot_b_r.ra;
        ev_rb <= ev_from_a_s ? slot_a_r.rb : slot_b_r.rb;
      end
      if (od_sel_s) begin
        od_op <= od_from_a_s ? slot_a_r.op : slot_b_r.op;
        od_rt <= od_from_a_s ? slot_a_r.rt : slot_b_r.rt;
        od_ra <= od_from_a_s ? slot_a_r.ra : slot_b_r.ra;
        od_rb <= od_from_a_s ? slot_a_r.rb : slot_b_r.rb;
      end
    end
  end

endmodule

// File: doc/spu_dual_issue_ctrl.md
# spu_dual_issue_ctrl

Dual-issue dispatch controller for the SPU. It accepts one decoded instruction pair per handshake and holds it in a two-slot buffer. It checks register hazards against a per-register latency scoreboard and routes each instruction to the even (fixed-point) or odd pipe, issuing both in one cycle when legal. It sits between the decoder and the NUM_PIPES execution pipes, and it stalls the decoder through a ready handshake.

## Interface
- NUM_REGS, 128, architectural register count
- REG_AW, 7, register-index width
- EVEN_LAT, 2, even-pipe result latency in cycles (1..7)
- ODD_LAT, 4, odd-pipe result latency in cycles (1..7)
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  pair present; slot0 is valid whenever in_valid=1
- in_ready  out  1  pair accepted when in_valid & in_ready
- in_v1  in  1  slot1 holds an instruction
- in_op0/in_op1  in  11  opcode, Opcodes type
- in_pipe0/in_pipe1  in  1  target pipe (0=even, 1=odd), from decoder
- in_rt0/ra0/rb0, in_rt1/ra1/rb1  in  REG_AW  dest and source indices
- in_use0/in_use1  in  3  {writes_rt, reads_rb, reads_ra}
- flush  in  1  discard buffered instructions
- ev_valid, od_valid  out  1  issue strobe per pipe, registered
- ev_op/od_op  out  11;  ev_rt/ra/rb, od_rt/ra/rb  out  REG_AW  issued fields, registered

## Operation
- States: EMPTY, HOLD2 (slots A=older and B both held), HOLD1 (only A held).
- Handshake and buffer load:
  - in_ready = EMPTY, or every held instruction issues this cycle.
  - in_ready is combinational from state and the scoreboard only, never from in_valid.
  - An accepted pair loads slot0→A and slot1→B; the state becomes HOLD2 if in_v1=1, else HOLD1.
- Hazards, for a held instruction X:
  - Each source X reads must have scoreboard counter 0.
  - X's rt, if X writes, must have counter 0 (WAW).
- A issues when it is hazard-free. Pipes never backpressure.
- B issues in the same cycle only if all of these hold:
  - A issues.
  - pipe(B) ≠ pipe(A).
  - B is hazard-free.
  - B has no intra-pair RAW or WAW on A's rt when A writes.
- B never issues before A. If A issues alone, B moves to A and the state becomes HOLD1. If both issue, the state becomes EMPTY or reloads.
- Scoreboard:
  - Per register, a 3-bit counter.
  - On issue of a writer, load EVEN_LAT or ODD_LAT according to its pipe.
  - Otherwise decrement when nonzero, saturating at 0.
  - A load wins over a decrement on the same register. Two loads on the same register in one cycle cannot occur, because WAW blocks B.
- Flush:
  - Clears A and B and sets the state to EMPTY.
  - Blocks acceptance in that cycle; in_ready=0 while flush=1.
  - Does not clear scoreboard counters, since in-flight writes still land.
  - Issue outputs in the flush cycle are still driven by that cycle's decision.
- Reset: state EMPTY, all counters 0, ev_valid=od_valid=0, all issue field outputs 0, in_ready=0 during reset.

## Timing
- Pair accepted in cycle c → decision in c+1 → ev/od outputs valid in c+2; the scoreboard is loaded at the end of c+1.
- A writer issued with outputs valid in cycle t blocks a dependent instruction until t+LAT+1.
- Minimum producer-to-consumer issue spacing: LAT+1 cycles.
- Independent pairs on opposite pipes sustain one pair per cycle, with in_ready held 1.
- A same-pipe pair takes two issue cycles, with in_ready=0 in the first.
- Reset asserted mid-operation: held instructions are dropped, and ev_valid/od_valid are 0 in the cycle after rst is sampled.

## Structure
- Shared defines package:
  - pipe_e enum {PIPE_EVEN, PIPE_ODD}.
  - EVEN_LAT and ODD_LAT default constants.
  - issue_pkt_t struct {Opcodes op, rt, ra, rb, use[2:0], pipe_e pipe}.
- Sub-module spu_scoreboard:
  - Counter array with two load ports (rt, latency, enable) and decrement-all.
  - Six combinational busy-read ports (ra, rb, rt for A and for B).

## Test plan
- Reset: rst=1 for 2 cycles → ev_valid=od_valid=0, in_ready=0; after release in_ready=1.
- Independent dual issue: pair {ADD_WORD r3←r1,r2, even} + {SHIFT_LEFT_HALFWORD_IMMEDIATE r5←r4, odd} accepted in c → ev_valid and od_valid both 1 in c+2.
- Same pipe: two even ADD_WORDs writing r3 and r6 → even issues r3 in c+2 and r6 in c+3; in_ready=0 in c+1.
- Intra-pair RAW: even r3←r1 + odd r7←r3 → odd issues no earlier than even issue +EVEN_LAT+1, i.e. c+5 with EVEN_LAT=2.
- WAW plus counter reload: odd write r9 (ODD_LAT=4), then even write r9 → even issue is delayed to odd issue +5; r9's counter reads 2 after the even issue.
- Flush with HOLD2 blocked on hazard: flush=1 → no issue of held instructions, state EMPTY, in_ready=1 the next cycle, scoreboard counters unchanged.
